// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and registered data-phase response mux.
// Includes a default slave that gives a two-cycle ERROR, and an error log.
module ahb_decoder_mux #(
  parameter int                      N_SLAVES  = 3,
  parameter logic [N_SLAVES*32-1:0]  SLV_BASE  = {32'h1F800000, 32'h00000000, 32'h1FC00000},
  parameter logic [N_SLAVES*32-1:0]  SLV_MASK  = {32'h1FC00000, 32'h10000000, 32'h1FC00000},
  parameter int                      ERR_CNT_W = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic [N_SLAVES-1:0]      HSEL,
  input  logic [N_SLAVES*32-1:0]   HRDATA_S,
  input  logic [N_SLAVES-1:0]      HREADYOUT_S,
  input  logic [N_SLAVES-1:0]      HRESP_S,
  output logic [31:0]              HRDATA,
  output logic                     HREADY,
  output logic                     HRESP,
  input  logic                     err_clr,
  output logic [ERR_CNT_W-1:0]     err_count,
  output logic [31:0]              err_addr
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  logic [N_SLAVES-1:0] match;
  logic                unmapped;
  logic [N_SLAVES:0]   sel_q;   // MSB = default slave, all zero = nothing selected
  state_t              state;
  logic                def_ready, def_resp;
  logic                err_evt;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_dec
      assign match[gi] = (HADDR & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
    end
  endgenerate

  assign unmapped = ~|match;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    HSEL = '0;
    for (int i = N_SLAVES-1; i >= 0; i--) begin
      if (match[i]) begin
        HSEL    = '0;
        HSEL[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    sel_q <= '0;
    else if (HREADY) sel_q <= {unmapped, HSEL};
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (sel_q[N_SLAVES]) begin
      HREADY = def_ready;
      HRESP  = def_resp;
    end else begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (sel_q[i]) begin
          HRDATA = HRDATA_S[32*i +: 32];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i];
        end
      end
    end
  end

  // ERR1 never starts a new error: its HREADY is low, the check just makes it explicit.
  assign err_evt = HREADY && HTRANS[1] && unmapped && (state != S_ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= S_IDLE;
      def_ready <= 1'b1;
      def_resp  <= 1'b0;
    end else if (err_evt) begin
      state     <= S_ERR1;
      def_ready <= 1'b0;
      def_resp  <= 1'b1;
    end else if (state == S_ERR1) begin
      state     <= S_ERR2;
      def_ready <= 1'b1;
      def_resp  <= 1'b1;
    end else begin
      state     <= S_IDLE;
      def_ready <= 1'b1;
      def_resp  <= 1'b0;
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_count <= '0;
      err_addr  <= '0;
    end else if (err_evt) begin
      err_addr <= HADDR;
      if (err_clr)                   err_count <= ERR_CNT_W'(1);
      else if (err_count != CNT_MAX) err_count <= err_count + ERR_CNT_W'(1);
    end else if (err_clr) begin
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed table-driven bench for ahb_decoder_mux (3 slaves, 2-bit error counter).
module tb_ahb_decoder_mux;

  logic         HCLK, HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HSEL;
  logic [95:0]  HRDATA_S;
  logic [2:0]   HREADYOUT_S, HRESP_S;
  logic [31:0]  HRDATA;
  logic         HREADY, HRESP;
  logic         err_clr;
  logic [1:0]   err_count;
  logic [31:0]  err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_decoder_mux #(.N_SLAVES(3), .ERR_CNT_W(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
    .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .err_clr(err_clr), .err_count(err_count), .err_addr(err_addr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  rdy;
    logic [2:0]  rsp;
    logic [2:0]  hsel;
    logic        ready;
    logic        resp;
    logic [31:0] rdata;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10;

  initial begin
    // addr, trans, rdy, rsp | hsel, ready, resp, rdata, cnt
    tbl[0]  = '{32'h1FC00010, NSQ, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 32'h00000000, 2'd0};
    tbl[1]  = '{32'h1F800004, NSQ, 3'b110, 3'b000, 3'b100, 1'b0, 1'b0, 32'hDEADBEEF, 2'd0};
    tbl[2]  = '{32'h1F800004, NSQ, 3'b111, 3'b000, 3'b100, 1'b1, 1'b0, 32'hDEADBEEF, 2'd0};
    tbl[3]  = '{32'h00000100, NSQ, 3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 32'h22222222, 2'd0};
    tbl[4]  = '{32'h1E000000, NSQ, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 32'h11111111, 2'd0};
    tbl[5]  = '{32'h00000100, IDL, 3'b111, 3'b000, 3'b010, 1'b0, 1'b1, 32'h00000000, 2'd1};
    tbl[6]  = '{32'h00000100, IDL, 3'b111, 3'b000, 3'b010, 1'b1, 1'b1, 32'h00000000, 2'd1};
    tbl[7]  = '{32'h1E000000, NSQ, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 32'h11111111, 2'd1};
    tbl[8]  = '{32'h1E000004, NSQ, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 32'h00000000, 2'd2};
    tbl[9]  = '{32'h1E000004, NSQ, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 32'h00000000, 2'd2};
    tbl[10] = '{32'h1E000008, IDL, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1, 32'h00000000, 2'd3};
    tbl[11] = '{32'h1E000008, IDL, 3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 32'h00000000, 2'd3};
    tbl[12] = '{32'h1E000008, IDL, 3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 32'h00000000, 2'd3};
    tbl[13] = '{32'h1FC00010, IDL, 3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 32'h00000000, 2'd3};
    tbl[14] = '{32'h00000100, NSQ, 3'b110, 3'b001, 3'b010, 1'b0, 1'b1, 32'hDEADBEEF, 2'd3};
    tbl[15] = '{32'h00000100, NSQ, 3'b111, 3'b001, 3'b010, 1'b1, 1'b1, 32'hDEADBEEF, 2'd3};
    tbl[16] = '{32'h00000100, IDL, 3'b111, 3'b000, 3'b010, 1'b1, 1'b0, 32'h11111111, 2'd3};

    HRESETn     = 1'b0;
    HADDR       = 32'h00000100;
    HTRANS      = IDL;
    HRDATA_S    = {32'h22222222, 32'h11111111, 32'hDEADBEEF};
    HREADYOUT_S = 3'b111;
    HRESP_S     = 3'b000;
    err_clr     = 1'b0;

    repeat (2) @(posedge HCLK);
    #1;
    chk("reset_hready", 32'(HREADY), 32'd1);
    chk("reset_hresp",  32'(HRESP),  32'd0);
    chk("reset_hrdata", HRDATA,      32'd0);
    chk("reset_cnt",    32'(err_count), 32'd0);
    chk("reset_addr",   err_addr,    32'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      HADDR       = tbl[i].addr;
      HTRANS      = tbl[i].trans;
      HREADYOUT_S = tbl[i].rdy;
      HRESP_S     = tbl[i].rsp;
      #1;
      chk($sformatf("row%0d_hsel", i),   32'(HSEL),      32'(tbl[i].hsel));
      chk($sformatf("row%0d_hready", i), 32'(HREADY),    32'(tbl[i].ready));
      chk($sformatf("row%0d_hresp", i),  32'(HRESP),     32'(tbl[i].resp));
      chk($sformatf("row%0d_hrdata", i), HRDATA,         tbl[i].rdata);
      chk($sformatf("row%0d_cnt", i),    32'(err_count), 32'(tbl[i].cnt));
      tick();
      if (i == 4)  chk("err_addr_single", err_addr, 32'h1E000000);
      if (i == 9)  chk("err_addr_b2b",    err_addr, 32'h1E000004);
    end
    chk("err_addr_after_idle", err_addr, 32'h1E000004);

    // Further error while the counter is already saturated.
    HADDR = 32'h1E000010; HTRANS = NSQ;
    #1 chk("sat_pre_hready", 32'(HREADY), 32'd1);
    tick();
    HADDR = 32'h00000100; HTRANS = IDL;
    #1;
    chk("sat_cnt",    32'(err_count), 32'd3);
    chk("sat_addr",   err_addr,       32'h1E000010);
    chk("sat_err1",   32'(HREADY),    32'd0);
    tick();
    #1 chk("sat_err2_resp", 32'(HRESP), 32'd1);
    tick();

    // Clear on its own.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("clr_cnt",  32'(err_count), 32'd0);
    chk("clr_addr", err_addr,       32'h1E000010);

    // Clear coincident with an error event.
    err_clr = 1'b1; HADDR = 32'h1E00000C; HTRANS = NSQ;
    tick();
    err_clr = 1'b0; HADDR = 32'h00000100; HTRANS = IDL;
    #1;
    chk("clr_evt_cnt",  32'(err_count), 32'd1);
    chk("clr_evt_addr", err_addr,       32'h1E00000C);
    chk("clr_evt_rdy",  32'(HREADY),    32'd0);
    chk("clr_evt_resp", 32'(HRESP),     32'd1);

    // Asynchronous reset in the middle of ERR1.
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_hready", 32'(HREADY),    32'd1);
    chk("async_rst_hresp",  32'(HRESP),     32'd0);
    chk("async_rst_cnt",    32'(err_count), 32'd0);
    chk("async_rst_addr",   err_addr,       32'd0);
    #2 HRESETn = 1'b1;
    tick();
    chk("post_rst_hready", 32'(HREADY), 32'd1);
    chk("post_rst_hrdata", HRDATA,      32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_decoder_mux.md
Name: ahb_decoder_mux

Overview:
- Parametrised AHB-Lite interconnect slice: address decode for N_SLAVES regions plus registered data-phase response multiplexer.
- Built-in default slave returns a two-cycle ERROR for transfers to unmapped addresses.
- Logs decode errors: saturating count and last faulting address.
- Sits between the core's AHB-Lite master port and the RAM/reset-RAM/GPIO slaves, replacing the purely combinational select decode.

Parameters:
- N_SLAVES, 3, number of mapped slave regions (1..8).
- SLV_BASE, {32'h1F800000, 32'h00000000, 32'h1FC00000}, N_SLAVES×32 flattened. Slot i occupies bits [32i+31:32i]. Default is slot0 reset RAM, slot1 RAM, slot2 GPIO.
- SLV_MASK, {32'h1FC00000, 32'h10000000, 32'h1FC00000}, N_SLAVES×32 flattened address-compare masks, same slot layout.
- ERR_CNT_W, 8, width of the decode-error counter.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- HADDR  input  32  address-phase address
- HTRANS  input  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HSEL  output  N_SLAVES  one-hot slave select, address phase
- HRDATA_S  input  N_SLAVES×32  slave read data, slot i at [32i+31:32i]
- HREADYOUT_S  input  N_SLAVES  per-slave ready
- HRESP_S  input  N_SLAVES  per-slave response (1 = ERROR)
- HRDATA  output  32  muxed read data to master
- HREADY  output  1  muxed ready to master and to all slaves
- HRESP  output  1  muxed response to master
- err_clr  input  1  synchronous clear of the error log
- err_count  output  ERR_CNT_W  saturating decode-error count
- err_addr  output  32  HADDR of the most recent decode error

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-transfer. On reset:
  - sel_q = none; FSM = IDLE.
  - HREADY=1, HRESP=0, HRDATA=0.
  - err_count=0, err_addr=0.
- Decode (combinational):
  - match[i] = ((HADDR & MASK[i]) == BASE[i]).
  - HSEL is one-hot; on overlap the lowest index wins.
  - HSEL is driven regardless of HTRANS, so slaves must qualify with HTRANS.
  - unmapped = no match[i].
- Data-phase select register sel_q (N_SLAVES+1 bits, extra bit = default slave):
  - Loads on the HCLK rising edge only when HREADY=1.
  - When HREADY=0 it holds, keeping wait-stated data phases stable.
- Response mux:
  - sel_q = slave i: HRDATA/HREADY/HRESP are driven by slot i.
  - sel_q = none: HREADY=1, HRESP=0, HRDATA=0.
  - sel_q = default: FSM outputs, with HRDATA=0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE → ERR1 on an edge with HREADY=1, HTRANS[1]=1 and unmapped. An unmapped IDLE/BUSY transfer stays in IDLE and gets a zero-wait OKAY.
  - ERR1 drives HREADY=0, HRESP=1. Always goes to ERR2 next cycle.
  - ERR2 drives HREADY=1, HRESP=1.
  - From ERR2 → ERR1 if the pipelined address phase is again an unmapped NONSEQ/SEQ; otherwise → IDLE.
  - Back-to-back errors therefore repeat the two-cycle pattern with no OKAY cycle between them.
- Error log:
  - Error event = IDLE→ERR1 or ERR2→ERR1 transition.
  - On an event, err_addr ← HADDR. err_count increments and saturates at 2^ERR_CNT_W−1.
  - err_clr with no event: err_count←0, err_addr held.
  - err_clr coincident with an event: err_count←1, err_addr←HADDR (event wins over clear).
- No combinational path from HREADYOUT_S to HSEL.
- Latency:
  - Mapped transfers add no wait states; slave timing passes through.
  - Unmapped NONSEQ/SEQ transfers take exactly 2 data-phase cycles.

Test Plan:
- Reset mid-ERR1: assert HRESETn=0 → HREADY=1, HRESP=0, err_count=0 immediately, with no HCLK edge required.
- NONSEQ read 0x1FC00010, slot0 HRDATA_S=0xDEADBEEF, 1 wait state → HSEL=3'b001, HREADY low 1 cycle, then HRDATA=0xDEADBEEF, HRESP=0. sel_q must hold through the wait.
- NONSEQ to 0x1F800004 then 0x00000100 back-to-back → HSEL 3'b100 then 3'b010. Data phases are returned from GPIO, then RAM, without bubble.
- NONSEQ to unmapped 0x1E000000 → data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1. err_count=1, err_addr=0x1E000000.
- Two consecutive unmapped NONSEQs, 0x1E000000 then 0x1E000004 → pattern ERR1,ERR2,ERR1,ERR2, err_count=2, err_addr=0x1E000004. An IDLE HTRANS to an unmapped address gives OKAY with no count change.
- Saturation and clear:
  - ERR_CNT_W=2, 5 errors → err_count=3.
  - err_clr alone → 0.
  - err_clr coincident with an error → 1.
